// File: rtl/hex_display_scanner.sv
// hex_display_scanner
//   Time-multiplexed driver for NUM_DIGITS seven-segment digits on a shared
//   segment bus. A packed hex value plus per-digit enable and blink masks are
//   captured on 'load'. The digits are then scanned round-robin, one slot of
//   REFRESH_DIV clocks per digit. Each slot starts with one all-off cycle to
//   avoid ghosting.
//
// Ports
//   clk                  system clock
//   reset                synchronous, active-high
//   load                 capture value / masks into the shadow registers
//   value                nibble k drives digit k (digit 0 = least significant)
//   digit_enable         0 = digit k forced blank
//   blink_mask           1 = digit k blinks
//   blank_leading_zeros  suppress leading zero digits (digit 0 always shown)
//   seg                  segments, bit0 = a ... bit6 = g (registered)
//   dig_sel              one-hot digit select (registered)
//
// Blink phase
//   state      | meaning
//   PH_VISIBLE | blinking digits are shown
//   PH_HIDDEN  | blinking digits are blanked

module hex_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     digit_enable,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      blank_leading_zeros,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     dig_sel
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    // XOR masks that turn active-high internal values into pin polarity;
    // they double as the all-off pattern.
    localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW != 0}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{ACTIVE_LOW != 0}};

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_HIDDEN  = 1'b1
    } phase_t;

    logic [4*NUM_DIGITS-1:0] sh_value;
    logic [NUM_DIGITS-1:0]   sh_enable;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic                    sh_blz;

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [FRM_W-1:0] frame;
    phase_t           phase;

    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  upper_zero;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] cur_onehot;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] dig_raw;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        cur_nib    = 4'h0;
        cur_blank  = 1'b1;
        cur_onehot = '0;
        seg_raw    = 7'h00;
        dig_raw    = '0;

        // Walk from the most significant digit down: a digit is a leading
        // zero while it and everything above it is zero. Digit 0 is exempt.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (sh_value[4*k +: 4] == 4'h0);
            if (k != 0) begin
                lz_blank[k] = sh_blz & upper_zero;
            end
        end

        // Explicit compare per digit keeps idx values past NUM_DIGITS-1
        // (non power-of-two banks) harmless.
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib       = sh_value[4*k +: 4];
                cur_blank     = !sh_enable[k]
                              || (sh_blink[k] && (phase == PH_HIDDEN))
                              || lz_blank[k];
                cur_onehot[k] = 1'b1;
            end
        end

        // cnt == 0 is the dead-time cycle at the start of every slot.
        if ((cnt != '0) && !cur_blank) begin
            seg_raw = glyph(cur_nib);
            dig_raw = cur_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_value  <= '0;
            sh_enable <= '1;
            sh_blink  <= '0;
            sh_blz    <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            frame     <= '0;
            phase     <= PH_VISIBLE;
            seg       <= SEG_OFF;
            dig_sel   <= DIG_OFF;
        end else begin
            if (load) begin
                sh_value  <= value;
                sh_enable <= digit_enable;
                sh_blink  <= blink_mask;
                sh_blz    <= blank_leading_zeros;
            end

            seg     <= seg_raw ^ SEG_OFF;
            dig_sel <= dig_raw ^ DIG_OFF;

            if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                    if (frame == FRM_LAST) begin
                        frame <= '0;
                        phase <= (phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
                    end else begin
                        frame <= frame + FRM_W'(1);
                    end
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner (4 digits, 4-clock slots,
// 2-frame blink, active-low pins). The reference model works from the
// number of clocks since reset: slot position, digit and blink phase are
// derived arithmetically from that count.

module tb_hex_display_scanner;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BF = 2;

    logic          clk;
    logic          reset;
    logic          load;
    logic [15:0]   value;
    logic [3:0]    digit_enable;
    logic [3:0]    blink_mask;
    logic          blank_leading_zeros;
    logic [6:0]    seg;
    logic [3:0]    dig_sel;

    hex_display_scanner #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .load                (load),
        .value               (value),
        .digit_enable        (digit_enable),
        .blink_mask          (blink_mask),
        .blank_leading_zeros (blank_leading_zeros),
        .seg                 (seg),
        .dig_sel             (dig_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Active-high glyph table a..g for 0..F.
    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: clocks since reset release plus the captured shadow.
    int          t;
    logic [15:0] m_val;
    logic [3:0]  m_en;
    logic [3:0]  m_bl;
    logic        m_blz;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_dig;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Expected pins for the cycle that follows an edge taken at time index tt.
    task automatic model_out(input int tt, output logic [6:0] s, output logic [3:0] d);
        int  pos, k, frm;
        bit  hidden, blank;
        pos    = tt % RD;
        k      = (tt / RD) % ND;
        frm    = tt / (RD * ND);
        hidden = ((frm / BF) % 2) == 1;
        blank  = (pos == 0) || !m_en[k] || (m_bl[k] && hidden)
               || (m_blz && (k != 0) && ((m_val >> (4 * k)) == 16'h0));
        if (blank) begin
            s = 7'h7F;
            d = 4'hF;
        end else begin
            s = ~glyph_tab[(m_val >> (4 * k)) & 16'hF];
            d = ~(4'b0001 << k);
        end
    endtask

    task automatic step(input bit rst, input bit ld);
        reset = rst;
        load  = ld;
        @(posedge clk);
        if (rst) begin
            exp_seg = 7'h7F;
            exp_dig = 4'hF;
            t       = 0;
            m_val   = 16'h0;
            m_en    = 4'hF;
            m_bl    = 4'h0;
            m_blz   = 1'b0;
        end else begin
            model_out(t, exp_seg, exp_dig);
            t++;
            if (ld) begin
                m_val = value;
                m_en  = digit_enable;
                m_bl  = blink_mask;
                m_blz = blank_leading_zeros;
            end
        end
        @(negedge clk);
        check("seg", 32'(seg), 32'(exp_seg));
        check("dig_sel", 32'(dig_sel), 32'(exp_dig));
        reset = 1'b0;
        load  = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic load_cfg(input logic [15:0] v, input logic [3:0] en,
                            input logic [3:0] bl, input logic blz);
        value               = v;
        digit_enable        = en;
        blink_mask          = bl;
        blank_leading_zeros = blz;
        step(1'b0, 1'b1);
    endtask

    initial begin
        reset               = 1'b1;
        load                = 1'b0;
        value               = 16'h0;
        digit_enable        = 4'hF;
        blink_mask          = 4'h0;
        blank_leading_zeros = 1'b0;
        t = 0; m_val = 0; m_en = 4'hF; m_bl = 0; m_blz = 0;

        // Reset held 3 cycles, then the first dead-time cycle and digit 0 showing 0.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("first_dead_seg", 32'(seg), 32'h7F);
        run(1);
        check("d0_zero_seg", 32'(seg), 32'h40);
        check("d0_zero_dig", 32'(dig_sel), 32'hE);
        run(20);

        // Plain hex display across all four slots.
        load_cfg(16'h12AF, 4'hF, 4'h0, 1'b0);
        while (t % 16 != 1) run(1);
        run(1);
        check("12AF_d0_seg", 32'(seg), 32'h0E);
        run(36);

        // Leading-zero suppression.
        load_cfg(16'h0005, 4'hF, 4'h0, 1'b1);
        run(32);
        load_cfg(16'h0000, 4'hF, 4'h0, 1'b1);
        run(32);
        load_cfg(16'h0105, 4'hF, 4'h0, 1'b1);
        run(32);

        // Blink on digit 0 across several phase toggles.
        load_cfg(16'h0007, 4'hF, 4'b0001, 1'b0);
        run(140);

        // Load landing on the last cycle of the last slot.
        while (t % 16 != 15) run(1);
        load_cfg(16'h9C3E, 4'hF, 4'h0, 1'b0);
        run(20);

        // Reset mid-scan at cnt=2, idx=2.
        while (t % 16 != 10) run(1);
        step(1'b1, 1'b0);
        check("midscan_reset_seg", 32'(seg), 32'h7F);
        run(20);

        // Digit 2 disabled.
        load_cfg(16'h4321, 4'b1011, 4'h0, 1'b0);
        run(36);

        // Back-to-back loads: last one wins.
        value = 16'h1111; step(1'b0, 1'b1);
        load_cfg(16'h8D6B, 4'hF, 4'h0, 1'b0);
        run(20);

        // Randomised loads and occasional resets.
        for (int i = 0; i < 600; i++) begin
            value               = 16'($urandom);
            digit_enable        = 4'($urandom);
            blink_mask          = 4'($urandom);
            blank_leading_zeros = 1'($urandom);
            if ($urandom_range(0, 3) == 0 && $urandom_range(0, 1) == 0) begin
                // Sparse values exercise leading-zero suppression.
                value = 16'(value >> (4 * $urandom_range(0, 4)));
            end
            step($urandom_range(0, 79) == 0, $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
